// File: rtl/clock_select_n_if.sv
// rtl/clock_select_n_if.sv - selection request / changeover status bundle for clock_select_n
`timescale 1ns/1ps
interface clock_select_n_if #(
  parameter int SELW = 2
);
  logic [SELW-1:0] SELECT;
  logic            SELECT_ENABLE;
  logic            BUSY;
  logic [SELW-1:0] CUR_SEL;
  logic            SEL_ERR;

  modport master (output SELECT, SELECT_ENABLE, input BUSY, CUR_SEL, SEL_ERR);
  modport slave  (input SELECT, SELECT_ENABLE, output BUSY, CUR_SEL, SEL_ERR);
endinterface

// File: rtl/clock_select_n.sv
// rtl/clock_select_n.sv - N-input clock selector with gated changeover and output reset hold
`timescale 1ns/1ps
module clock_select_n #(
  parameter int NCLK     = 4,
  parameter int SELW     = 2,
  parameter int GATE_CYC = 2,
  parameter int RSTDELAY = 2,
  parameter int RST_SEL  = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  clock_select_n_if.slave sel_if,
  input  logic [NCLK-1:0] CLK_IN,
  input  logic [NCLK-1:0] CLKGATE_IN,
  output logic            CLK_OUT,
  output logic            CLK_GATE_OUT,
  output logic            OUT_RST_N
);
  localparam int CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, GATE_OFF, SWITCH, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SELW-1:0] cur_sel, cur_sel_nxt;
  logic [SELW-1:0] pend_sel, pend_sel_nxt;
  logic            gate_block, gate_block_nxt;
  logic            sel_err, sel_err_nxt;
  logic            clear_req;
  logic [1:0]      hold_sync;
  logic [RSTDELAY:0] reset_hold;
  logic            shift_clr;
  logic            hold_done;
  logic            gate_mux;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= HOLD;
      cnt        <= '0;
      cur_sel    <= SELW'(RST_SEL);
      pend_sel   <= SELW'(RST_SEL);
      gate_block <= 1'b0;
      sel_err    <= 1'b0;
      clear_req  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_sel    <= cur_sel_nxt;
      pend_sel   <= pend_sel_nxt;
      gate_block <= gate_block_nxt;
      sel_err    <= sel_err_nxt;
      // Registered so the shifter clear lands on the same edge as the mux switch.
      clear_req  <= (state == SWITCH);
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_sel_nxt    = cur_sel;
    pend_sel_nxt   = pend_sel;
    gate_block_nxt = gate_block;
    sel_err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_if.SELECT_ENABLE) begin
          if (int'(sel_if.SELECT) >= NCLK) begin
            sel_err_nxt = 1'b1;
          end else if (sel_if.SELECT != cur_sel) begin
            pend_sel_nxt   = sel_if.SELECT;
            gate_block_nxt = 1'b1;
            cnt_nxt        = CW'(GATE_CYC - 1);
            state_nxt      = GATE_OFF;
          end
        end
      end
      GATE_OFF: begin
        if (cnt == '0) state_nxt = SWITCH;
        else           cnt_nxt   = cnt - 1'b1;
      end
      SWITCH: begin
        cur_sel_nxt = pend_sel;
        state_nxt   = HOLD;
      end
      HOLD: begin
        gate_block_nxt = 1'b0;
        if (hold_sync[1]) state_nxt = IDLE;
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign shift_clr = !RST_N || clear_req;

  always_ff @(posedge CLK_OUT or posedge shift_clr) begin
    if (shift_clr) reset_hold <= '0;
    else           reset_hold <= (RSTDELAY+1)'({reset_hold, 1'b1});
  end

  assign hold_done = reset_hold[RSTDELAY];
  assign OUT_RST_N = reset_hold[RSTDELAY];

  // Flushed outside HOLD so a stale done from the previous changeover cannot end the next one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              hold_sync <= 2'b00;
    else if (state != HOLD)  hold_sync <= 2'b00;
    else                     hold_sync <= {hold_sync[0], hold_done};
  end

  always_comb begin
    CLK_OUT  = 1'b0;
    gate_mux = 1'b0;
    for (int i = 0; i < NCLK; i++) begin
      if (cur_sel == SELW'(i)) begin
        CLK_OUT  = CLK_IN[i];
        gate_mux = CLKGATE_IN[i];
      end
    end
  end

  assign CLK_GATE_OUT   = gate_mux & ~gate_block;
  assign sel_if.BUSY    = (state != IDLE);
  assign sel_if.CUR_SEL = cur_sel;
  assign sel_if.SEL_ERR = sel_err;
endmodule
